// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port RAM shared by the display prefetcher and a writer.
// Reads are prefetched into a small FIFO and popped one pixel per pix_tick while de is high.
module vga_fb_arbiter #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_tick,
    input  logic              de,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb,
    output logic              underrun
);

    localparam int unsigned PIX_TOTAL = H_RES * V_RES;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(PIX_TOTAL);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q;
    logic              drop_q;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [DATA_W-1:0] rgb_q;
    logic              underrun_q;

    logic [CNT_W-1:0]  occ_c;
    logic              fetch_c;
    logic              wr_fire_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_empty_c;

    // Arbitration: an eligible fetch always wins; the writer takes any other slot outside PREFILL.
    always_comb begin
        occ_c        = fifo_cnt_q + CNT_W'(inflight_q);
        fetch_c      = 1'b0;
        wr_fire_c    = 1'b0;
        fifo_empty_c = (fifo_cnt_q == '0);
        push_c       = inflight_q && !drop_q;
        pop_c        = pix_tick && de && !fifo_empty_c;
        if (!rst) begin
            if ((state_q == ST_PREFILL || state_q == ST_RUN) &&
                (occ_c < CNT_FULL) && (fetch_addr_q < ADDR_END)) begin
                fetch_c = 1'b1;
            end
            if (!fetch_c && state_q != ST_PREFILL) begin
                wr_fire_c = wr_valid;
            end
        end
    end

    assign wr_ready  = wr_fire_c;
    assign mem_en    = fetch_c || wr_fire_c;
    assign mem_we    = wr_fire_c;
    assign mem_addr  = fetch_c ? fetch_addr_q : (wr_fire_c ? wr_addr : '0);
    assign mem_wdata = wr_fire_c ? wr_data : '0;
    assign rgb       = rgb_q;
    assign underrun  = underrun_q;

    // Next-state logic; frame_start restarts the fetch stream from any state.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_PREFILL: if (occ_c == CNT_FULL) state_d = ST_RUN;
            ST_RUN:     if (fetch_addr_q == ADDR_END) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
        if (fetch_c) begin
            fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        end
        if (frame_start) begin
            state_d      = ST_PREFILL;
            fetch_addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // A read issued alongside frame_start belongs to the old frame and is tagged for discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            inflight_q <= fetch_c;
            drop_q     <= fetch_c && frame_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (frame_start) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    // Pixel output: blank during !de, black plus sticky underrun when the FIFO runs dry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (pix_tick) begin
                rgb_q <= pop_c ? fifo_mem_q[rd_ptr_q] : '0;
            end
            if (frame_start) begin
                underrun_q <= 1'b0;
            end else if (pix_tick && de && fifo_empty_c) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push_c && fifo_cnt_q == CNT_FULL));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x4 frame with an addr=data RAM model.
module tb_vga_fb_arbiter;

    localparam int unsigned H    = 16;
    localparam int unsigned V    = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 12;
    localparam int unsigned NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_tick;
    logic          de;
    logic          frame_start;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rgb;
    logic          underrun;

    logic [DW-1:0] ram [1 << AW];
    logic          ram_init;
    logic          bw_win;
    int            bw_cyc = 0;
    int            bw_rdy = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic          seen;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .de(de), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rgb(rgb), .underrun(underrun)
    );

    // Synchronous single-port RAM, read data one clock after the access.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (bw_win) begin
            bw_cyc <= bw_cyc + 1;
            if (wr_ready) bw_rdy <= bw_rdy + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic d);
        pix_tick = 1'b1;
        de       = d;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        de       = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input int p, input int exp);
        pix(1'b1);
        check($sformatf("pix%0d", p), 32'(rgb), 32'(exp));
        idle(3);
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ram_init = 1'b1; pix_tick = 1'b0; de = 1'b0; frame_start = 1'b0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0; bw_win = 1'b0; seen = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ram_init = 1'b0; wr_valid = 1'b0;
        idle(2);

        // Frame 1: writer served in IDLE, then fetch-only prefill of addresses 0..7
        wr_valid = 1'b1; wr_addr = 8'd200; wr_data = 12'h555;
        @(negedge clk);
        check("idle_wr", 32'({wr_ready, mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, 1'b1, 8'd200}));
        @(posedge clk); #1;
        fstart();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("prefill_wr_ready%0d", k), 32'(wr_ready), 32'd0);
            if (k < 8) check($sformatf("prefill_rd%0d", k), 32'({mem_en, mem_we, mem_addr}),
                             32'({1'b1, 1'b0, 8'(k)}));
            else       check("prefill_stop", 32'(mem_en), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("run_wr_grant", 32'({wr_ready, mem_we, mem_addr}), 32'({1'b1, 1'b1, 8'd200}));
        @(posedge clk); #1;
        wr_valid = 1'b0;

        for (int p = 0; p < 40; p++) begin
            if (p == 16 || p == 32) begin
                pix(1'b0);
                check("blank_rgb", 32'(rgb), 32'd0);
                check("blank_cnt", 32'(dut.fifo_cnt_q), 32'd8);
                idle(3);
            end
            pop_check(p, p);
        end
        // Two pops two clocks apart: the second coincides with a push
        pix(1'b1);
        check("burst_pix40", 32'(rgb), 32'd40);
        idle(1);
        pix(1'b1);
        check("burst_pix41", 32'(rgb), 32'd41);
        check("pushpop_cnt", 32'(dut.fifo_cnt_q), 32'd7);
        idle(3);
        for (int p = 42; p < int'(NPIX); p++) pop_check(p, p);
        check("no_underrun", 32'(underrun), 32'd0);

        pix(1'b1);
        check("underrun_rgb", 32'(rgb), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);
        idle(3);
        pix(1'b0);
        idle(10);
        check("underrun_sticky", 32'(underrun), 32'd1);

        wr_valid = 1'b1; wr_addr = 8'd201; wr_data = 12'h123;
        @(negedge clk);
        check("done_wr", 32'({wr_ready, mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, 1'b1, 8'd201}));
        @(posedge clk); #1;
        wr_valid = 1'b0;

        // Frame 2: writer streams into addr 60 during RUN, picked up later in the same frame
        fstart();
        @(negedge clk);
        check("underrun_clr", 32'(underrun), 32'd0);
        @(posedge clk); #1;
        idle(8);
        wr_valid = 1'b1; wr_addr = 8'd60; wr_data = 12'hABC; bw_win = 1'b1;
        for (int p = 0; p < 4; p++) pop_check(p, p);
        bw_win = 1'b0; wr_valid = 1'b0;
        check("wr_bandwidth", 32'(bw_rdy * 4 >= bw_cyc * 3 && bw_cyc > 0), 32'd1);
        for (int p = 4; p < int'(NPIX); p++) pop_check(p, (p == 60) ? 12'hABC : p);

        // Frame 3: frame_start one clock after the read of addr 50
        fstart();
        idle(10);
        for (int c = 0; c < 600 && !seen; c++) begin
            pix_tick = (c % 4 == 0);
            de       = 1'b1;
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 8'd50) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("drop_seen_rd50", 32'(seen), 32'd1);
        @(posedge clk); #1;
        pix_tick = 1'b0; de = 1'b0; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("refetch_addr0", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'd0}));
        idle(12);
        pix(1'b1);
        check("drop_first_rgb", 32'(rgb), 32'd0);
        check("drop_underrun", 32'(underrun), 32'd0);
        idle(3);
        pop_check(1, 1);
        pop_check(2, 2);

        // Asynchronous reset while running
        #2;
        rst = 1'b1; wr_valid = 1'b1;
        @(negedge clk);
        check("midrst_rgb", 32'(rgb), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_nofetch", 32'(mem_en), 32'd0);
        idle(3);
        @(negedge clk);
        check("post_rst_idle", 32'(mem_en), 32'd0);
        check("post_rst_cnt", 32'(dut.fifo_cnt_q), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
